// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage.
// Stalls IF..EX while a MULT/DIV runs, then writes HI/LO.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        exc_oc,
  output logic        stall_o,
  output logic        busy,
  output logic [1:0]  hilo_wen,
  output logic [31:0] hilo_hiwdata,
  output logic [31:0] hilo_lowdata
);

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic [31:0] r_hi_q;
  logic [31:0] r_lo_q;

  logic        w_idle;
  logic        w_acc;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_mul_end;
  logic        w_div_end;
  logic        w_in_sgn;
  logic        w_sgn;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_ea;
  logic [63:0] w_eb;
  logic [63:0] w_prod;
  logic [32:0] w_sh;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [31:0] w_rem_n;
  logic [31:0] w_quo_n;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_idle = (r_state == S_IDLE);
  assign w_acc  = w_idle & op_valid & ~exc_oc & ~op[2];
  assign w_mthi = w_idle & op_valid & ~exc_oc
                & (op == 3'd4);
  assign w_mtlo = w_idle & op_valid & ~exc_oc
                & (op == 3'd5);

  assign w_mul_end = (r_state == S_MUL)
                   & (r_cnt == 6'(MUL_LAT - 1));
  assign w_div_end = (r_state == S_DIV)
                   & (r_cnt == 6'd31);

  // Ops 0 and 2 are the signed variants
  assign w_in_sgn = ~op[0];
  assign w_sgn    = ~r_op[0];

  assign w_abs_a = (w_in_sgn & src_a[31]) ? -src_a : src_a;
  assign w_abs_b = (w_in_sgn & src_b[31]) ? -src_b : src_b;

  // Sign/zero extension makes one 64-bit multiply serve both
  assign w_ea   = {{32{w_sgn & r_a[31]}}, r_a};
  assign w_eb   = {{32{w_sgn & r_b[31]}}, r_b};
  assign w_prod = w_ea * w_eb;

  // One restoring step: remainder stays below the divisor
  assign w_sh    = {r_rem, r_quo[31]};
  assign w_diff  = w_sh - {1'b0, r_dvs};
  assign w_fits  = ~w_diff[32];
  assign w_rem_n = w_fits ? w_diff[31:0] : w_sh[31:0];
  assign w_quo_n = {r_quo[30:0], w_fits};

  assign w_q_fix = (w_sgn & (r_a[31] ^ r_b[31]))
                 ? -w_quo_n : w_quo_n;
  assign w_r_fix = (w_sgn & r_a[31])
                 ? -w_rem_n : w_rem_n;

  assign busy = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; a flush always returns to idle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) w_next = op[1] ? S_DIV : S_MUL;
      end
      S_MUL: begin
        if (exc_oc)         w_next = S_IDLE;
        else if (w_mul_end) w_next = S_DONE;
      end
      S_DIV: begin
        if (exc_oc)         w_next = S_IDLE;
        else if (w_div_end) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stall, write enables and write data
  always_comb begin
    stall_o      = 1'b0;
    hilo_wen     = 2'b00;
    hilo_hiwdata = r_hi_q;
    hilo_lowdata = r_lo_q;
    if (resetn) begin
      unique case (r_state)
        S_IDLE: begin
          stall_o = w_acc;
          if (w_mthi) begin
            hilo_wen     = 2'b10;
            hilo_hiwdata = src_a;
          end
          if (w_mtlo) begin
            hilo_wen     = 2'b01;
            hilo_lowdata = src_a;
          end
        end
        S_MUL, S_DIV: stall_o = ~exc_oc;
        S_DONE: begin
          if (!exc_oc) begin
            hilo_wen     = 2'b11;
            hilo_hiwdata = r_res_hi;
            hilo_lowdata = r_res_lo;
          end
        end
        default: stall_o = 1'b0;
      endcase
    end
  end

  // Operand latch, step counter, divider and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_hi_q   <= '0;
      r_lo_q   <= '0;
    end else begin
      r_hi_q <= hilo_hiwdata;
      r_lo_q <= hilo_lowdata;
      if (w_acc) begin
        r_op  <= op;
        r_a   <= src_a;
        r_b   <= src_b;
        r_cnt <= '0;
        r_rem <= '0;
        r_quo <= w_abs_a;
        r_dvs <= w_abs_b;
      end else if (r_state == S_MUL) begin
        r_cnt <= r_cnt + 6'd1;
        if (w_mul_end) begin
          r_res_hi <= w_prod[63:32];
          r_res_lo <= w_prod[31:0];
        end
      end else if (r_state == S_DIV) begin
        r_cnt <= r_cnt + 6'd1;
        r_rem <= w_rem_n;
        r_quo <= w_quo_n;
        if (w_div_end) begin
          if (r_b == 32'd0) begin
            r_res_hi <= r_a;
            r_res_lo <= 32'hFFFF_FFFF;
          end else begin
            r_res_hi <= w_r_fix;
            r_res_lo <= w_q_fix;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised bench for muldiv_ctrl with a cycle-level
// expectation schedule and arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        exc_oc;
  logic        stall_o;
  logic        busy;
  logic [1:0]  hilo_wen;
  logic [31:0] hilo_hiwdata;
  logic [31:0] hilo_lowdata;

  logic        e_stall;
  logic        e_busy;
  logic [1:0]  e_wen;
  logic [31:0] e_hi;
  logic [31:0] e_lo;
  logic        chk;
  logic        chkd;

  int vectors = 0;
  int miscompares = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .op_valid     (op_valid),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .exc_oc       (exc_oc),
    .stall_o      (stall_o),
    .busy         (busy),
    .hilo_wen     (hilo_wen),
    .hilo_hiwdata (hilo_hiwdata),
    .hilo_lowdata (hilo_lowdata)
  );

  always #5 clk = ~clk;

  // Reference: {HI, LO} for ops 0..3 from plain arithmetic
  function automatic logic [63:0] ref_res(
    input logic [2:0] o, input logic [31:0] a,
    input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Single compare process, mid-cycle
  always @(negedge clk) begin
    if (chk) begin
      vectors++;
      if (stall_o !== e_stall) begin
        miscompares++;
        $display("FAIL stall_o got %b want %b t=%0t",
                 stall_o, e_stall, $time);
      end
      if (busy !== e_busy) begin
        miscompares++;
        $display("FAIL busy got %b want %b t=%0t",
                 busy, e_busy, $time);
      end
      if (hilo_wen !== e_wen) begin
        miscompares++;
        $display("FAIL hilo_wen got %b want %b t=%0t",
                 hilo_wen, e_wen, $time);
      end
      if ((e_wen[1] || chkd) && hilo_hiwdata !== e_hi) begin
        miscompares++;
        $display("FAIL hiwdata got %h want %h t=%0t",
                 hilo_hiwdata, e_hi, $time);
      end
      if ((e_wen[0] || chkd) && hilo_lowdata !== e_lo) begin
        miscompares++;
        $display("FAIL lowdata got %h want %h t=%0t",
                 hilo_lowdata, e_lo, $time);
      end
    end
  end

  task automatic cyc(
    input logic v, input logic [2:0] o,
    input logic [31:0] a, input logic [31:0] b,
    input logic x, input logic es, input logic eb,
    input logic [1:0] ew, input logic [31:0] eh,
    input logic [31:0] el, input logic ck,
    input logic ckd);
    op_valid = v;
    op       = o;
    src_a    = a;
    src_b    = b;
    exc_oc   = x;
    e_stall  = es;
    e_busy   = eb;
    e_wen    = ew;
    e_hi     = eh;
    e_lo     = el;
    chk      = ck;
    chkd     = ckd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 3'd7, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
  endtask

  // One MULT/DIV instruction; exk = stall cycle of flush
  // (1..n in MUL/DIV, n+1 = DONE), 0 = none
  task automatic run_op(
    input logic [2:0] o, input logic [31:0] a,
    input logic [31:0] b, input int exk,
    input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = o[1] ? 32 : MUL_LAT;
    cyc(1, o, a, b, 0, 1, 0, 2'b00, 0, 0, 1, 0);
    for (int k = 1; k <= n; k++) begin
      if (k == exk) begin
        cyc(1, o, a, b, 1, 0, 1, 2'b00, 0, 0, 1, 0);
        idle();
        return;
      end
      cyc(1, o, a, b, 0, 1, 1, 2'b00, 0, 0, 1, 0);
    end
    if (exk == n + 1) begin
      cyc(1, o, a, b, 1, 0, 1, 2'b00, 0, 0, 1, 0);
      idle();
      return;
    end
    cyc(1, o, a, b, 0, 0, 1, 2'b11, eh, el, 1, 0);
  endtask

  task automatic mt(input logic [2:0] o,
                    input logic [31:0] a, input logic x);
    logic [1:0] w;
    w = x ? 2'b00 : ((o == 3'd4) ? 2'b10 : 2'b01);
    cyc(1, o, a, 32'h1234, x, 0, 0, w, a, a, 1, 0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    logic [2:0]  o;
    logic [31:0] a, b;
    int ex;
    resetn = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    resetn = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1);

    run_op(0, 32'hFFFF_FFFD, 7, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
           32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2, -32'd7, 2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(3, 100, 7, 0, 32'd2, 32'd14);
    run_op(3, 1234, 0, 0, 32'd1234, 32'hFFFF_FFFF);
    run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 0,
           32'd0, 32'h8000_0000);
    run_op(2, 1000, 3, 10, 0, 0);
    idle();
    mt(4, 32'hA5A5_A5A5, 0);
    mt(5, 32'h5A5A_5A5A, 0);
    mt(4, 32'h1111_2222, 1);
    cyc(1, 6, 1, 2, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    cyc(1, 7, 1, 2, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    run_op(1, 5, 6, MUL_LAT + 1, 0, 0);

    // Reset in the middle of a divide
    cyc(1, 3, 99, 5, 0, 1, 0, 2'b00, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++)
      cyc(1, 3, 99, 5, 0, 1, 1, 2'b00, 0, 0, 1, 0);
    resetn = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    resetn = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1);

    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rnd_val();
      b = rnd_val();
      if (o <= 3'd3) begin
        ex = ($urandom_range(0, 7) == 0)
           ? $urandom_range(1, o[1] ? 33 : MUL_LAT + 1)
           : 0;
        r = ref_res(o, a, b);
        run_op(o, a, b, ex, r[63:32], r[31:0]);
      end else if (o <= 3'd5) begin
        mt(o, a, $urandom_range(0, 5) == 0);
      end else begin
        cyc(1, o, a, b, $urandom_range(0, 1), 0, 0,
            2'b00, 0, 0, 1, 0);
      end
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
